// File: rtl/alien_bomb.sv
// -----------------------------------------------------------------------------
// alien_bomb
//   Downward projectile engine for the alien formation. It holds a single bomb
//   slot. On a fire request it draws the bomb, and on each frame tick it erases
//   the bomb, moves it down STEP rows and redraws it. It reports a rocket hit or
//   a bottom exit as a one-cycle pulse and then frees the slot. Pixels are
//   written through the shared VGA plotter with a drawEn/drawAck handshake.
//
//   Optional feature: define ALIEN_BOMB_LFSR_FIRE_EN to add LFSR-driven
//   self-firing while the slot is idle.
//
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   tick           one-cycle frame-step strobe
//   fireReq        launch request, with fireX (8b) / fireY (7b) launch position
//   rocketX        rocket left column (8b)
//   drawAck        plotter accepted the current pixel
//   bombX, bombY   current bomb position
//   colour         pixel colour for the plotter
//   drawEn         pixel write request
//   bombActive     bomb slot occupied
//   hitRocket      one-cycle pulse: bomb struck the rocket
//   bottomReached  one-cycle pulse: bomb left the playfield
// -----------------------------------------------------------------------------
module alien_bomb #(
    parameter int         STEP     = 3,
    parameter int         Y_BOTTOM = 115,
    parameter int         ROCKET_Y = 108,
    parameter int         ROCKET_W = 8,
    parameter logic [2:0] COLOUR   = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       fireReq,
    input  logic [7:0] fireX,
    input  logic [6:0] fireY,
    input  logic [7:0] rocketX,
    input  logic       drawAck,
    output logic [7:0] bombX,
    output logic [6:0] bombY,
    output logic [2:0] colour,
    output logic       drawEn,
    output logic       bombActive,
    output logic       hitRocket,
    output logic       bottomReached
);

    localparam logic [7:0] STEP8     = 8'(STEP);
    localparam logic [7:0] Y_BOTTOM8 = 8'(Y_BOTTOM);
    localparam logic [7:0] ROCKET_Y8 = 8'(ROCKET_Y);
    localparam logic [8:0] RW_M1     = 9'(ROCKET_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        WAIT  = 3'd2,
        ERASE = 3'd3,
        MOVE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] bomb_x_q, bomb_x_d;
    logic [6:0] bomb_y_q, bomb_y_d;
    logic       hit_q, hit_d;
    logic       bottom_q, bottom_d;

    // Collision / exit terms. yNext is 8 bits so a bomb near row 127 cannot
    // wrap back to the top; the hitbox right edge is 9 bits for rocketX near 255.
    logic [7:0] y_next;
    logic [8:0] rocket_right;
    logic       hit;

    assign y_next       = {1'b0, bomb_y_q} + STEP8;
    assign rocket_right = {1'b0, rocketX} + RW_M1;
    assign hit          = (y_next >= ROCKET_Y8) && (bomb_x_q >= rocketX) &&
                          ({1'b0, bomb_x_q} <= rocket_right);

`ifdef ALIEN_BOMB_LFSR_FIRE_EN
    // 8-bit Fibonacci LFSR, taps 8,6,5,4, advancing on every tick.
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;
    logic       self_fire;

    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d    = tick ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
    assign self_fire = tick && (lfsr_q[2:0] == 3'b000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        bomb_x_d = bomb_x_q;
        bomb_y_d = bomb_y_q;
        hit_d    = 1'b0;
        bottom_d = 1'b0;
        case (state_q)
            IDLE: begin
                // fireReq has priority over a self-fire in the same cycle.
                if (fireReq) begin
                    bomb_x_d = fireX;
                    bomb_y_d = fireY;
                    state_d  = DRAW;
                end
`ifdef ALIEN_BOMB_LFSR_FIRE_EN
                else if (self_fire) begin
                    bomb_x_d = fireX ^ {3'b000, lfsr_q[7:3]};
                    bomb_y_d = fireY;
                    state_d  = DRAW;
                end
`endif
            end
            DRAW:  if (drawAck) state_d = WAIT;
            WAIT:  if (tick)    state_d = ERASE;
            ERASE: if (drawAck) state_d = MOVE;
            MOVE: begin
                // The erase is already done, so a retiring bomb is not redrawn.
                if (hit) begin
                    hit_d   = 1'b1;
                    state_d = IDLE;
                end else if (y_next >= Y_BOTTOM8) begin
                    bottom_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    bomb_y_d = y_next[6:0];
                    state_d  = DRAW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bomb_x_q <= '0;
            bomb_y_q <= '0;
            hit_q    <= 1'b0;
            bottom_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bomb_x_q <= bomb_x_d;
            bomb_y_q <= bomb_y_d;
            hit_q    <= hit_d;
            bottom_q <= bottom_d;
        end
    end

    // Decoded from the state register, so reset clears them asynchronously.
    assign bombX         = bomb_x_q;
    assign bombY         = bomb_y_q;
    assign drawEn        = (state_q == DRAW) || (state_q == ERASE);
    assign colour        = (state_q == DRAW) ? COLOUR : 3'b000;
    assign bombActive    = (state_q != IDLE);
    assign hitRocket     = hit_q;
    assign bottomReached = bottom_q;

endmodule

// File: tb/tb_alien_bomb.sv
// -----------------------------------------------------------------------------
// tb_alien_bomb
//   Self-checking bench for alien_bomb: a table of per-cycle vectors for the
//   main launch/step/hit/exit flows, plus hand-written sequences for a stalled
//   plotter, asynchronous reset mid-erase and LFSR self-fire.
// -----------------------------------------------------------------------------
module tb_alien_bomb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       fireReq = 1'b0;
    logic [7:0] fireX = '0;
    logic [6:0] fireY = '0;
    logic [7:0] rocketX = '0;
    logic       drawAck = 1'b1;
    logic [7:0] bombX;
    logic [6:0] bombY;
    logic [2:0] colour;
    logic       drawEn;
    logic       bombActive;
    logic       hitRocket;
    logic       bottomReached;

    alien_bomb dut (
        .clk(clk), .reset(reset), .tick(tick), .fireReq(fireReq),
        .fireX(fireX), .fireY(fireY), .rocketX(rocketX), .drawAck(drawAck),
        .bombX(bombX), .bombY(bombY), .colour(colour), .drawEn(drawEn),
        .bombActive(bombActive), .hitRocket(hitRocket),
        .bottomReached(bottomReached)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst, fire, tk, ack;
        logic [7:0] fx;
        logic [6:0] fy;
        logic [7:0] rx;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ecol;
        logic       een, eact, ehit, ebot;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] outs();
        return {bombX, bombY, colour, drawEn, bombActive, hitRocket, bottomReached};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, fire, tk, ack, input logic [7:0] fx,
                       input logic [6:0] fy, input logic [7:0] rx,
                       input logic [7:0] ex, input logic [6:0] ey,
                       input logic [2:0] ecol, input logic een, eact, ehit, ebot);
        vec_t v;
        v.rst = rst; v.fire = fire; v.tk = tk; v.ack = ack;
        v.fx = fx; v.fy = fy; v.rx = rx;
        v.ex = ex; v.ey = ey; v.ecol = ecol;
        v.een = een; v.eact = eact; v.ehit = ehit; v.ebot = ebot;
        vecs.push_back(v);
    endtask

    // One cycle of inputs driven on the falling edge.
    task automatic drive(input logic f, t, a);
        @(negedge clk);
        fireReq = f; tick = t; drawAck = a;
    endtask

    initial begin
        // rst fire tick ack  fx   fy  rx  |  x    y  col en act hit bot
        // Launch at (40,20), then one full step
        add(0,1,0,1,  40, 20,  0,   40, 20, 4,1,1,0,0); // DRAW
        add(0,0,0,1,   0,  0,  0,   40, 20, 0,0,1,0,0); // WAIT
        add(0,0,0,1,   0,  0,  0,   40, 20, 0,0,1,0,0); // WAIT holds
        add(0,0,1,1,   0,  0,  0,   40, 20, 0,1,1,0,0); // ERASE
        add(0,0,0,1,   0,  0,  0,   40, 20, 0,0,1,0,0); // MOVE
        add(0,0,0,1,   0,  0,  0,   40, 23, 4,1,1,0,0); // DRAW at 23
        add(0,0,0,1,   0,  0,  0,   40, 23, 0,0,1,0,0); // WAIT
        add(1,0,0,1,   0,  0,  0,    0,  0, 0,0,0,0,0); // reset
        // Hit: rocketX=36, bomb (40,106) -> yNext 109
        add(0,1,0,1,  40,106, 36,   40,106, 4,1,1,0,0);
        add(0,0,0,1,   0,  0, 36,   40,106, 0,0,1,0,0);
        add(0,0,1,1,   0,  0, 36,   40,106, 0,1,1,0,0);
        add(0,0,0,1,   0,  0, 36,   40,106, 0,0,1,0,0);
        add(0,0,0,1,   0,  0, 36,   40,106, 0,0,0,1,0); // hit pulse, no redraw
        add(0,0,0,1,   0,  0, 36,   40,106, 0,0,0,0,0); // pulse one clock
        // Bottom exit: rocketX=100, bomb (40,113) -> yNext 116
        add(0,1,0,1,  40,113,100,   40,113, 4,1,1,0,0);
        add(0,0,0,1,   0,  0,100,   40,113, 0,0,1,0,0);
        add(0,0,1,1,   0,  0,100,   40,113, 0,1,1,0,0);
        add(0,0,0,1,   0,  0,100,   40,113, 0,0,1,0,0);
        add(0,0,0,1,   0,  0,100,   40,113, 0,0,0,0,1); // bottom pulse
        add(0,0,0,1,   0,  0,100,   40,113, 0,0,0,0,0);
        // rocketX=250, bombX=255: right edge 257, no wrap -> hit
        add(0,1,0,1, 255,106,250,  255,106, 4,1,1,0,0);
        add(0,0,0,1,   0,  0,250,  255,106, 0,0,1,0,0);
        add(0,0,1,1,   0,  0,250,  255,106, 0,1,1,0,0);
        add(0,0,0,1,   0,  0,250,  255,106, 0,0,1,0,0);
        add(0,0,0,1,   0,  0,250,  255,106, 0,0,0,1,0);
        // rocketX=33: span 33..40, column 40 is the last hit column
        add(0,1,0,1,  40,106, 33,   40,106, 4,1,1,0,0);
        add(0,0,0,1,   0,  0, 33,   40,106, 0,0,1,0,0);
        add(0,0,1,1,   0,  0, 33,   40,106, 0,1,1,0,0);
        add(0,0,0,1,   0,  0, 33,   40,106, 0,0,1,0,0);
        add(0,0,0,1,   0,  0, 33,   40,106, 0,0,0,1,0);
        // rocketX=32: span 32..39, column 40 just outside -> keeps falling
        add(0,1,0,1,  40,106, 32,   40,106, 4,1,1,0,0);
        add(0,0,0,1,   0,  0, 32,   40,106, 0,0,1,0,0);
        add(0,0,1,1,   0,  0, 32,   40,106, 0,1,1,0,0);
        add(0,0,0,1,   0,  0, 32,   40,106, 0,0,1,0,0);
        add(0,0,0,1,   0,  0, 32,   40,109, 4,1,1,0,0); // redrawn at 109
        add(0,0,0,1,   0,  0, 32,   40,109, 0,0,1,0,0);
        add(1,0,0,1,   0,  0,  0,    0,  0, 0,0,0,0,0); // reset
        // fireReq+tick in IDLE: fire only; drawAck stall holds DRAW
        add(0,1,1,1,  10,  5,  0,   10,  5, 4,1,1,0,0);
        add(0,0,0,0,   0,  0,  0,   10,  5, 4,1,1,0,0); // stalled
        add(0,0,0,1,   0,  0,  0,   10,  5, 0,0,1,0,0); // WAIT
        add(0,0,0,1,   0,  0,  0,   10,  5, 0,0,1,0,0); // no ERASE
        add(0,1,0,1,  99, 99,  0,   10,  5, 0,0,1,0,0); // fire ignored
        add(0,0,1,1,   0,  0,  0,   10,  5, 0,1,1,0,0); // ERASE

        // Reset state
        repeat (2) @(posedge clk);
        #1 chk("reset_state", 32'(outs()), 32'h0);
        @(negedge clk) reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; fireReq = vecs[i].fire; tick = vecs[i].tk;
            drawAck = vecs[i].ack; fireX = vecs[i].fx; fireY = vecs[i].fy;
            rocketX = vecs[i].rx;
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), 32'(outs()),
                   32'({vecs[i].ex, vecs[i].ey, vecs[i].ecol, vecs[i].een,
                        vecs[i].eact, vecs[i].ehit, vecs[i].ebot}));
        end

        // Stalled plotter in ERASE: tick and fireReq pulses must be dropped
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0; rocketX = 8'd0;
        fireX = 8'd60; fireY = 7'd30;
        drive(1, 0, 1);                 // -> DRAW
        drive(0, 0, 1);                 // -> WAIT
        fireX = 8'd1; fireY = 7'd1;
        drive(0, 1, 0);                 // -> ERASE, plotter stalled
        begin
            int bad = 0;
            for (int c = 0; c < 10; c++) begin
                drive((c == 3 || c == 6), (c == 2 || c == 6), 0);
                @(posedge clk); #1;
                if (outs() !== {8'd60, 7'd30, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0}) bad++;
            end
            chk("erase_stall_cycles_bad", bad, 0);
        end
        drive(0, 0, 1);                 // ack -> MOVE
        drive(0, 0, 1);                 // -> DRAW
        @(posedge clk); #1;
        chk("after_stall_draw", 32'(outs()),
            32'({8'd60, 7'd33, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0}));

        // Asynchronous reset mid-ERASE, checked before the next clock edge
        drive(0, 0, 1);                 // -> WAIT
        drive(0, 1, 0);                 // -> ERASE
        @(posedge clk); #1;
        chk("pre_reset_erase", 32'({drawEn, bombActive}), 32'b11);
        #1 reset = 1'b1;
        #1 chk("async_reset_outs", 32'(outs()), 32'h0);
        @(negedge clk) reset = 1'b0; tick = 1'b0; drawAck = 1'b1;

        // Self-fire: no fireReq, 64 ticks
        begin
            int fires = 0;
            int ybad = 0;
            logic prev_act = 1'b0;
            fireX = 8'd0; fireY = 7'd50; rocketX = 8'd0;
            for (int t = 0; t < 64; t++) begin
                for (int c = 0; c < 4; c++) begin
                    drive(0, (c == 0), 1);
                    @(posedge clk); #1;
                    if (bombActive && !prev_act) begin
                        fires++;
                        if (bombY !== 7'd50) ybad++;
                    end
                    prev_act = bombActive;
                end
            end
            chk("self_fire_bombY_bad", ybad, 0);
`ifdef ALIEN_BOMB_LFSR_FIRE_EN
            chk("self_fire_seen", 32'(fires > 0), 32'd1);
`else
            chk("self_fire_count", fires, 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
